sprite_ram_loader: RTL and testbench
====================================

# sprite_ram_loader

Writer side of the 64x64 sprite memory read by the sprite draw blocks. Accepts a byte stream (valid/ready) carrying a small header and packed 12-bit RGB pixels, and writes each pixel into the write port of a dual-port sprite RAM at address {y[5:0], x[5:0]}, the same layout the draw blocks read. Sits between a host/UART byte source and the sprite RAM, so sprites can be replaced at run time instead of being fixed in ROM.

## Interface
- SYNC_BYTE, 8'hA5, packet start marker
- CLEAR_VALUE, 12'hFFF, value written by the clear pass (transparent colour)
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
- wr_en  out  1  sprite RAM write strobe
- wr_addr  out  12  {y[5:0], x[5:0]}
- wr_data  out  12  {R[3:0], G[3:0], B[3:0]}
- busy  out  1  packet in progress (sync accepted, not yet done)
- done  out  1  one-cycle pulse, packet fully written
- error  out  1  one-cycle pulse, malformed header

## Operation
- Packet: SYNC_BYTE, W-1, H-1, then pixel bytes. W-1 and H-1 use bits [5:0]; bits [7:6] must be 0.
- Pixels raster order (x fastest), two pixels per 3 bytes: b0={R0,G0}, b1={B0,R1}, b2={G1,B1} (high nibble first).
- N = W*H pixels, byte count ceil(N/2)*3. If N odd, second pixel of final triple is discarded (no write).
- Only the W x H window at top-left (0,0) is written; other locations untouched.
- States: IDLE -> HDR_W -> HDR_H -> [CLEAR] -> PIX0 -> PIX1 -> PIX2 -> PIX0 ... -> IDLE.
  - IDLE: bytes != SYNC_BYTE accepted and dropped; SYNC_BYTE -> HDR_W, busy=1.
  - HDR_W/HDR_H: latch W-1/H-1; bits [7:6] nonzero -> error pulse, busy=0, IDLE.
  - PIX0 stores R0,G0; PIX1 completes pixel 0 (write); PIX2 completes pixel 1 (write).
  - After the write of pixel N-1 -> IDLE; if N odd, the last pixel completes in PIX1, so PIX2 is still consumed (dropped) before IDLE.
- x increments per pixel; at x==W-1, x<=0 and y<=y+1. Counters are 6-bit; max W=H=64 never wraps past the window.
- SYNC_BYTE inside header/pixel data is data, not resync.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0; state IDLE, counters 0.
- in_ready=1 from first clock after reset release, except during CLEAR (see Configuration).
- One byte per cycle max; in_valid gaps of any length allowed, state held.
- Write latency: wr_en/wr_addr/wr_data registered, valid the cycle after the completing byte is accepted; wr_en is 1 cycle wide; at most one write per cycle.
- done pulses in the same cycle as the final wr_en (odd N: the cycle after the final padding byte is accepted, with no wr_en); busy falls in that cycle.
- error pulses the cycle after the bad header byte is accepted.
- A new SYNC_BYTE is acceptable the cycle after done.
- Reset mid-packet: immediate return to IDLE, outputs to reset values; RAM contents already written remain.

## Configuration
- SPRITE_LOADER_CLEAR_EN defined: after HDR_H accepts, enter CLEAR: in_ready=0, write CLEAR_VALUE to all 4096 addresses 0..4095 one per cycle (wr_en high 4096 consecutive cycles), then PIX0 with in_ready=1. Bad header skips CLEAR.
- Not defined: CLEAR state absent; HDR_H -> PIX0 directly, in_ready never drops outside reset.

## Test plan
- A5,01,00,F0,0A,BC (2x1) -> writes addr 0x000=F00, 0x001=ABC; done with second write; busy low after.
- A5,00,00,12,3F,FF (1x1, odd) -> single write 0x000=123; final byte accepted, no second write; done pulses the cycle after final byte.
- Garbage 00,FF,A4 then A5,01,01 + 6 pixel bytes (2x2) -> garbage dropped; writes at 0x000,0x001,0x040,0x041; no error.
- A5,40 -> error pulse, busy 0, no writes; following valid packet loads normally.
- Reset asserted after 2nd pixel byte of 2x2 packet -> all outputs 0 immediately; next full packet loads correctly from x=y=0.
- With SPRITE_LOADER_CLEAR_EN: A5,00,00,… -> 4096 writes of FFF, in_ready=0 throughout, then pixel write to 0x000; without macro, pixel write follows header with no clear writes.

Source files
------------

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: turns a sync/header/packed-RGB byte stream into sprite RAM writes.
// Optional SPRITE_LOADER_CLEAR_EN: fill all 4096 locations with CLEAR_VALUE before the pixels.
module sprite_ram_loader (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam logic [11:0] CLEAR_VALUE = 12'hFFF;

`ifdef SPRITE_LOADER_CLEAR_EN
    typedef enum logic [2:0] {IDLE, HDR_W, HDR_H, CLEAR, PIX0, PIX1, PIX2} state_t;
    logic [11:0] clr, clr_n;
`else
    typedef enum logic [2:0] {IDLE, HDR_W, HDR_H, PIX0, PIX1, PIX2} state_t;
`endif

    state_t      state, state_n;
    logic [5:0]  wm1, wm1_n, hm1, hm1_n, x, x_n, y, y_n, x_inc, y_inc;
    logic [7:0]  hold, hold_n;
    logic        odd, odd_n, in_ready_n, wr_en_n, busy_n, done_n, error_n;
    logic [11:0] wr_addr_n, wr_data_n;
    logic        acc, wrap, last, hdr_bad;

    assign acc     = in_valid && in_ready;
    assign wrap    = x == wm1;
    assign last    = wrap && y == hm1;
    assign hdr_bad = |in_data[7:6];
    assign x_inc   = wrap ? 6'd0 : x + 6'd1;
    assign y_inc   = wrap ? y + 6'd1 : y;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            wm1      <= '0;
            hm1      <= '0;
            x        <= '0;
            y        <= '0;
            hold     <= '0;
            odd      <= 1'b0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef SPRITE_LOADER_CLEAR_EN
            clr      <= '0;
`endif
        end else begin
            state    <= state_n;
            wm1      <= wm1_n;
            hm1      <= hm1_n;
            x        <= x_n;
            y        <= y_n;
            hold     <= hold_n;
            odd      <= odd_n;
            in_ready <= in_ready_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
`ifdef SPRITE_LOADER_CLEAR_EN
            clr      <= clr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        wm1_n     = wm1;
        hm1_n     = hm1;
        x_n       = x;
        y_n       = y;
        hold_n    = hold;
        odd_n     = odd;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = 1'b0;
`ifdef SPRITE_LOADER_CLEAR_EN
        clr_n     = clr;
`endif
        case (state)
            IDLE: if (acc && in_data == SYNC_BYTE) begin
                state_n = HDR_W;
                busy_n  = 1'b1;
                x_n     = '0;
                y_n     = '0;
                odd_n   = 1'b0;
            end
            HDR_W: if (acc) begin
                wm1_n   = in_data[5:0];
                state_n = hdr_bad ? IDLE : HDR_H;
                error_n = hdr_bad;
                busy_n  = !hdr_bad;
            end
            HDR_H: if (acc) begin
                hm1_n   = in_data[5:0];
                error_n = hdr_bad;
                busy_n  = !hdr_bad;
`ifdef SPRITE_LOADER_CLEAR_EN
                state_n = hdr_bad ? IDLE : CLEAR;
                clr_n   = '0;
`else
                state_n = hdr_bad ? IDLE : PIX0;
`endif
            end
`ifdef SPRITE_LOADER_CLEAR_EN
            CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = clr;
                wr_data_n = CLEAR_VALUE;
                clr_n     = clr + 12'd1;
                state_n   = &clr ? PIX0 : CLEAR;
            end
`endif
            PIX0: if (acc) begin
                hold_n  = in_data;
                state_n = PIX1;
            end
            PIX1: if (acc) begin
                wr_en_n   = 1'b1;
                wr_addr_n = {y, x};
                wr_data_n = {hold, in_data[7:4]};
                hold_n    = {4'h0, in_data[3:0]};
                x_n       = x_inc;
                y_n       = y_inc;
                odd_n     = last;
                state_n   = PIX2;
            end
            PIX2: if (acc) begin
                if (!odd) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = {y, x};
                    wr_data_n = {hold[3:0], in_data};
                    x_n       = x_inc;
                    y_n       = y_inc;
                end
                done_n  = odd || last;
                busy_n  = !(odd || last);
                state_n = (odd || last) ? IDLE : PIX0;
            end
            default: state_n = IDLE;
        endcase
    end

    // hold in_ready low until the last clear write has left the register
`ifdef SPRITE_LOADER_CLEAR_EN
    assign in_ready_n = state_n != CLEAR && state != CLEAR;
`else
    assign in_ready_n = 1'b1;
`endif
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: table vectors, reset/busy sequences and random packets checked
// against a pixel-level model of the sprite loader.
module tb_sprite_ram_loader;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, wr_en, busy, done, error;
    logic [11:0] wr_addr, wr_data;

`ifdef SPRITE_LOADER_CLEAR_EN
    localparam int NCLR = 4096;
`else
    localparam int NCLR = 0;
`endif

    sprite_ram_loader dut (
        .clk(clk), .resetN(resetN), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nb;
        logic [7:0] b [12];
        int         nw;
        bit         err;
        bit         odd;
        logic [23:0] first;
        logic [23:0] last;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0, done_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0;
    logic done_wr = 1'b0;
    logic [7:0]  pkt [$];
    logic [23:0] wq [$], exp_w [$];
    logic        rq [$];
    logic [15:0] mem [4096], exp_mem [4096];
    vec_t        v [5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (resetN) begin
        if (wr_en) begin
            wq.push_back({wr_addr, wr_data});
            rq.push_back(in_ready);
            mem[wr_addr] = {4'h0, wr_data};
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_wr = wr_en;
        end
        if (error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_pkt(input int gap_max);
        wq.delete();
        rq.delete();
        done_cnt = 0;
        err_cnt = 0;
        foreach (pkt[k]) send(pkt[k], int'($urandom_range(gap_max, 0)));
        repeat (4) @(negedge clk);
    endtask

    // Expected writes computed pixel by pixel from the packed-triple layout.
    task automatic model(input int off, input int w, input int h);
        logic [7:0]  b0, b1, b2;
        logic [11:0] d;
        int a;
        exp_w.delete();
        for (int c = 0; c < NCLR; c++) begin
            exp_w.push_back({12'(c), 12'hFFF});
            exp_mem[c] = 16'h0FFF;
        end
        for (int p = 0; p < w * h; p++) begin
            b0 = pkt[off + 3 * (p / 2)];
            b1 = pkt[off + 3 * (p / 2) + 1];
            b2 = pkt[off + 3 * (p / 2) + 2];
            d = (p % 2 == 0) ? {b0, b1[7:4]} : {b1[3:0], b2};
            a = (p / w) * 64 + (p % w);
            exp_w.push_back({12'(a), d});
            exp_mem[a] = {4'h0, d};
        end
    endtask

    task automatic cmp_run(input int w, input int h);
        int n, bad;
        chk("pkt_nwr", wq.size(), exp_w.size());
        n = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
        for (int i = 0; i < n; i++) chk($sformatf("pkt_wr%0d", i), wq[i], exp_w[i]);
        bad = 0;
        for (int i = 0; i < NCLR && i < rq.size(); i++) if (rq[i]) bad++;
        if (NCLR > 0) chk("clr_ready_low", bad, 0);
        chk("pkt_done", done_cnt, 1);
        chk("pkt_err", err_cnt, 0);
        chk("pkt_done_cyc", done_cyc, last_acc);
        chk("pkt_done_wr", done_wr, ((w * h) % 2) == 0);
        chk("pkt_busy_end", busy, 0);
    endtask

    initial begin
        int w, h, g, n_exp, bad;
        logic [7:0] b;
        v[0].nb = 6;  v[0].b = '{8'hA5, 8'h01, 8'h00, 8'hF0, 8'h0A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v[0].nw = 2;  v[0].err = 0; v[0].odd = 0; v[0].first = {12'h000, 12'hF00}; v[0].last = {12'h001, 12'hABC};
        v[1].nb = 6;  v[1].b = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v[1].nw = 1;  v[1].err = 0; v[1].odd = 1; v[1].first = {12'h000, 12'h123}; v[1].last = {12'h000, 12'h123};
        v[2].nb = 12; v[2].b = '{8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h01, 8'h01, 8'h11, 8'h12, 8'h22, 8'h33, 8'h34, 8'h44};
        v[2].nw = 4;  v[2].err = 0; v[2].odd = 0; v[2].first = {12'h000, 12'h111}; v[2].last = {12'h041, 12'h444};
        v[3].nb = 2;  v[3].b = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v[3].nw = 0;  v[3].err = 1; v[3].odd = 0; v[3].first = '0; v[3].last = '0;
        v[4].nb = 3;  v[4].b = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        v[4].nw = 0;  v[4].err = 1; v[4].odd = 0; v[4].first = '0; v[4].last = '0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, wr_en, wr_addr, wr_data, busy, done, error}, 0);
        resetN = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            pkt.delete();
            for (int k = 0; k < v[i].nb; k++) pkt.push_back(v[i].b[k]);
            run_pkt(0);
            n_exp = v[i].nw + (v[i].err ? 0 : NCLR);
            chk($sformatf("tbl%0d_nwr", i), wq.size(), n_exp);
            if (v[i].nw > 0 && wq.size() == n_exp) begin
                chk($sformatf("tbl%0d_first", i), wq[NCLR], v[i].first);
                chk($sformatf("tbl%0d_last", i), wq[n_exp - 1], v[i].last);
            end
            chk($sformatf("tbl%0d_done", i), done_cnt, v[i].err ? 0 : 1);
            chk($sformatf("tbl%0d_err", i), err_cnt, v[i].err ? 1 : 0);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
            if (v[i].err) chk($sformatf("tbl%0d_err_cyc", i), err_cyc, last_acc);
            else begin
                chk($sformatf("tbl%0d_done_cyc", i), done_cyc, last_acc);
                chk($sformatf("tbl%0d_done_wr", i), done_wr, !v[i].odd);
            end
        end

        send(8'hA5, 0);
        @(negedge clk);
        chk("busy_after_sync", busy, 1);
        send(8'h01, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h12, 0);
        @(negedge clk);
        chk("busy_mid_packet", busy, 1);
        #1 resetN = 1'b0;
        #1 chk("reset_mid_outputs", {in_ready, wr_en, wr_addr, wr_data, busy, done, error}, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", in_ready, 1);
        pkt.delete();
        pkt.push_back(8'hA5); pkt.push_back(8'h01); pkt.push_back(8'h01);
        repeat (6) pkt.push_back(8'($urandom));
        model(3, 2, 2);
        run_pkt(1);
        cmp_run(2, 2);

        for (int a = 0; a < 4096; a++) begin
            mem[a] = 16'hDEAD;
            exp_mem[a] = 16'hDEAD;
        end
        for (int r = 0; r < 7; r++) begin
            w = (r == 6) ? 64 : int'($urandom_range(9, 1));
            h = (r == 6) ? 64 : int'($urandom_range(9, 1));
            g = (r == 6) ? 0 : int'($urandom_range(3, 0));
            pkt.delete();
            repeat (g) begin
                b = 8'($urandom);
                pkt.push_back(b == 8'hA5 ? 8'h5A : b);
            end
            pkt.push_back(8'hA5);
            pkt.push_back(8'(w - 1));
            pkt.push_back(8'(h - 1));
            repeat (((w * h + 1) / 2) * 3) pkt.push_back(8'($urandom));
            model(g + 3, w, h);
            run_pkt(r == 6 ? 0 : 2);
            cmp_run(w, h);
        end
        bad = 0;
        for (int a = 0; a < 4096; a++) if (mem[a] !== exp_mem[a]) bad++;
        chk("ram_contents", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
